// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO write and read controllers.
// Pointer widths up to MAX_PTR_W are handled by zero-extending into ptr_t.
package fifo_pkg;

    localparam int MAX_PTR_W = 9;

    typedef logic [MAX_PTR_W-1:0] ptr_t;

    function automatic int fifo_depth(input int ptr_sz);
        return 1 << ptr_sz;
    endfunction

    // Leading zeros map to leading zeros, so narrower pointers convert correctly.
    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync2.sv
// Two-flop synchroniser for multi-bit Gray pointers crossing clock domains.
module fifo_sync2 #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-domain controller for the router's dual-clock FIFOs: pointer, RAM write
// port, synchronised read pointer and registered full/almost-full/level/overflow.
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_SZ       = 2,
    parameter int AFULL_THRESH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winc,
    input  logic              ovf_clr,
    input  logic [PTR_SZ:0]   rgray_async,
    output logic              write_en,
    output logic [PTR_SZ-1:0] waddr,
    output logic [PTR_SZ:0]   waddr_gray,
    output logic              wfull,
    output logic              walmost_full,
    output logic [PTR_SZ:0]   wlevel,
    output logic              woverflow
);

    localparam int PW    = PTR_SZ + 1;
    localparam int DEPTH = fifo_depth(PTR_SZ);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rq2_rgray;
    logic [PW-1:0] rq2_rbin;
    logic [PW-1:0] full_pattern;
    logic [PW-1:0] level_next;
    ptr_t          gray_wide;
    ptr_t          rbin_wide;
    logic          unused_hi_bits;

    fifo_sync2 #(
        .WIDTH(PW)
    ) u_rptr_sync (
        .clk (clk),
        .rst (rst),
        .d   (rgray_async),
        .q   (rq2_rgray)
    );

    assign write_en  = winc & ~wfull;
    assign waddr     = wbin[PTR_SZ-1:0];
    assign wbin_next = wbin + PW'(write_en);

    assign gray_wide  = bin2gray(MAX_PTR_W'(wbin_next));
    assign wgray_next = gray_wide[PW-1:0];
    assign rbin_wide  = gray2bin(MAX_PTR_W'(rq2_rgray));
    assign rq2_rbin   = rbin_wide[PW-1:0];

    // Upper bits are always zero after zero-extension; fold them away explicitly.
    assign unused_hi_bits = ^(gray_wide >> PW) ^ ^(rbin_wide >> PW);

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign full_pattern = {~rq2_rgray[PTR_SZ:PTR_SZ-1], rq2_rgray[PTR_SZ-2:0]};
    assign level_next   = wbin_next - rq2_rbin;

    // All flags derive from next-state values so they stay mutually consistent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbin         <= '0;
            waddr_gray   <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            waddr_gray   <= wgray_next;
            wfull        <= (wgray_next == full_pattern);
            walmost_full <= (level_next >= PW'(AFULL_THRESH));
            wlevel       <= level_next;
            woverflow    <= (woverflow & ~ovf_clr) | (winc & wfull);
        end
    end

    // DEPTH is kept for readability of the threshold range (1..DEPTH).
    logic unused_depth;
    assign unused_depth = (DEPTH == 0);

endmodule
